// File: rtl/pixel_unmap.sv
// Inverse perspective mapper: maps a display pixel back to its source pixel through
// a 3x3 inverse homography, using two parallel bit-serial restoring dividers.
module pixel_unmap #(
   parameter int COEF_W = 18,
   parameter int NUM_W  = COEF_W + 13
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [9:0]               dx,
   input  logic [8:0]               dy,
   input  logic signed [COEF_W-1:0] q1,
   input  logic signed [COEF_W-1:0] q2,
   input  logic signed [COEF_W-1:0] q3,
   input  logic signed [COEF_W-1:0] q4,
   input  logic signed [COEF_W-1:0] q5,
   input  logic signed [COEF_W-1:0] q6,
   input  logic signed [COEF_W-1:0] q7,
   input  logic signed [COEF_W-1:0] q8,
   input  logic signed [COEF_W-1:0] q9,
   output logic                     busy,
   output logic                     valid,
   output logic [9:0]               sx,
   output logic [8:0]               sy,
   output logic                     in_range
);

   localparam int PROD_W = COEF_W + 11;
   localparam int CNT_W  = $clog2(NUM_W);

   typedef enum logic [2:0] {IDLE, MULT, SUM, DIV, DONE} state_t;

   state_t                   state;
   logic [9:0]               dx_r;
   logic [8:0]               dy_r;
   logic signed [COEF_W-1:0] q1_r, q2_r, q3_r, q4_r, q5_r, q6_r, q7_r, q8_r, q9_r;
   logic signed [PROD_W-1:0] p1dx, p2dy, p4dx, p5dy, p7dx, p8dy;
   logic [NUM_W-1:0]         den;
   logic                     neg_x, neg_y;
   logic [NUM_W-1:0]         mag_x, mag_y, mag_d;
   logic [NUM_W-1:0]         rem_x, rem_y, quo_x, quo_y;
   logic [CNT_W-1:0]         cnt;

   logic signed [10:0]       cx, cy;
   logic signed [NUM_W-1:0]  sum_x, sum_y, sum_d;
   logic [NUM_W:0]           sh_x, sh_y;
   logic                     ge_x, ge_y;
   logic [NUM_W-1:0]         nrem_x, nrem_y;
   logic signed [NUM_W-1:0]  qx, qy;
   logic                     hit;

   function automatic logic [NUM_W-1:0] mag(input logic signed [NUM_W-1:0] v);
      return v[NUM_W-1] ? -v : v;
   endfunction

   always_comb begin
      cx    = {1'b0, dx_r};
      cy    = {2'b00, dy_r};
      sum_x = NUM_W'(p1dx) + NUM_W'(p2dy) + NUM_W'(q3_r);
      sum_y = NUM_W'(p4dx) + NUM_W'(p5dy) + NUM_W'(q6_r);
      sum_d = NUM_W'(p7dx) + NUM_W'(p8dy) + NUM_W'(q9_r);
   end

   // The numerator magnitudes double as shift registers feeding the remainders MSB first.
   always_comb begin
      sh_x   = {rem_x, mag_x[NUM_W-1]};
      sh_y   = {rem_y, mag_y[NUM_W-1]};
      ge_x   = sh_x >= {1'b0, mag_d};
      ge_y   = sh_y >= {1'b0, mag_d};
      nrem_x = ge_x ? NUM_W'(sh_x - {1'b0, mag_d}) : sh_x[NUM_W-1:0];
      nrem_y = ge_y ? NUM_W'(sh_y - {1'b0, mag_d}) : sh_y[NUM_W-1:0];
   end

   always_comb begin
      qx  = neg_x ? -signed'(quo_x) : signed'(quo_x);
      qy  = neg_y ? -signed'(quo_y) : signed'(quo_y);
      hit = (den != '0)
            && !qx[NUM_W-1] && (qx <= NUM_W'(639))
            && !qy[NUM_W-1] && (qy <= NUM_W'(479));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         valid    <= 1'b0;
         sx       <= '0;
         sy       <= '0;
         in_range <= 1'b0;
         dx_r     <= '0;
         dy_r     <= '0;
         q1_r     <= '0; q2_r <= '0; q3_r <= '0;
         q4_r     <= '0; q5_r <= '0; q6_r <= '0;
         q7_r     <= '0; q8_r <= '0; q9_r <= '0;
         p1dx     <= '0; p2dy <= '0; p4dx <= '0;
         p5dy     <= '0; p7dx <= '0; p8dy <= '0;
         den      <= '0;
         neg_x    <= 1'b0;
         neg_y    <= 1'b0;
         mag_x    <= '0;
         mag_y    <= '0;
         mag_d    <= '0;
         rem_x    <= '0;
         rem_y    <= '0;
         quo_x    <= '0;
         quo_y    <= '0;
         cnt      <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dx_r  <= dx;
                  dy_r  <= dy;
                  q1_r  <= q1; q2_r <= q2; q3_r <= q3;
                  q4_r  <= q4; q5_r <= q5; q6_r <= q6;
                  q7_r  <= q7; q8_r <= q8; q9_r <= q9;
                  busy  <= 1'b1;
                  state <= MULT;
               end
            end
            MULT: begin
               p1dx  <= PROD_W'(q1_r) * PROD_W'(cx);
               p2dy  <= PROD_W'(q2_r) * PROD_W'(cy);
               p4dx  <= PROD_W'(q4_r) * PROD_W'(cx);
               p5dy  <= PROD_W'(q5_r) * PROD_W'(cy);
               p7dx  <= PROD_W'(q7_r) * PROD_W'(cx);
               p8dy  <= PROD_W'(q8_r) * PROD_W'(cy);
               state <= SUM;
            end
            SUM: begin
               den   <= sum_d;
               neg_x <= sum_x[NUM_W-1] ^ sum_d[NUM_W-1];
               neg_y <= sum_y[NUM_W-1] ^ sum_d[NUM_W-1];
               mag_x <= mag(sum_x);
               mag_y <= mag(sum_y);
               mag_d <= mag(sum_d);
               rem_x <= '0;
               rem_y <= '0;
               quo_x <= '0;
               quo_y <= '0;
               cnt   <= CNT_W'(NUM_W - 1);
               state <= DIV;
            end
            DIV: begin
               rem_x <= nrem_x;
               rem_y <= nrem_y;
               mag_x <= {mag_x[NUM_W-2:0], 1'b0};
               mag_y <= {mag_y[NUM_W-2:0], 1'b0};
               quo_x <= {quo_x[NUM_W-2:0], ge_x};
               quo_y <= {quo_y[NUM_W-2:0], ge_y};
               if (cnt == '0) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               in_range <= hit;
               sx       <= hit ? qx[9:0] : '0;
               sy       <= hit ? qy[8:0] : '0;
               valid    <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_unmap.sv
// Directed and randomized bench for pixel_unmap, checked against an integer-arithmetic
// reference model of the inverse homography.
module tb_pixel_unmap;

   localparam int COEF_W = 18;
   localparam int NUM_W  = COEF_W + 13;
   localparam int LAT    = NUM_W + 3;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic                     start;
   logic [9:0]               dx;
   logic [8:0]               dy;
   logic signed [COEF_W-1:0] q [1:9];
   logic                     busy, valid, in_range;
   logic [9:0]               sx;
   logic [8:0]               sy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   pixel_unmap #(.COEF_W(COEF_W), .NUM_W(NUM_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .dx(dx), .dy(dy),
      .q1(q[1]), .q2(q[2]), .q3(q[3]), .q4(q[4]), .q5(q[5]),
      .q6(q[6]), .q7(q[7]), .q8(q[8]), .q9(q[9]),
      .busy(busy), .valid(valid), .sx(sx), .sy(sy), .in_range(in_range)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_q(input int c1, c2, c3, c4, c5, c6, c7, c8, c9);
      q[1] = COEF_W'(c1); q[2] = COEF_W'(c2); q[3] = COEF_W'(c3);
      q[4] = COEF_W'(c4); q[5] = COEF_W'(c5); q[6] = COEF_W'(c6);
      q[7] = COEF_W'(c7); q[8] = COEF_W'(c8); q[9] = COEF_W'(c9);
   endtask

   // Reference: exact rational mapping, quotient truncated toward zero.
   function automatic void model(input int dxv, input int dyv,
                                 output logic [31:0] esx, output logic [31:0] esy,
                                 output logic [31:0] ein);
      longint nx, ny, nd, qxv, qyv;
      nx = longint'(q[1]) * dxv + longint'(q[2]) * dyv + longint'(q[3]);
      ny = longint'(q[4]) * dxv + longint'(q[5]) * dyv + longint'(q[6]);
      nd = longint'(q[7]) * dxv + longint'(q[8]) * dyv + longint'(q[9]);
      esx = 0; esy = 0; ein = 0;
      if (nd != 0) begin
         qxv = nx / nd;
         qyv = ny / nd;
         if (qxv >= 0 && qxv <= 639 && qyv >= 0 && qyv <= 479) begin
            esx = 32'(qxv);
            esy = 32'(qyv);
            ein = 1;
         end
      end
   endfunction

   task automatic request(input int dxv, input int dyv, input string tag);
      logic [31:0] esx, esy, ein;
      int lat, busy_hi;
      model(dxv, dyv, esx, esy, ein);
      dx = 10'(dxv);
      dy = 9'(dyv);
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, "_busy_rise"}, busy, 1);
      lat = 0;
      busy_hi = 0;
      for (int k = 1; k <= LAT + 20; k++) begin
         step();
         if (valid) begin
            lat = k;
            break;
         end
         if (busy) busy_hi++;
      end
      check({tag, "_latency"}, lat, LAT);
      check({tag, "_busy_cycles"}, busy_hi, LAT - 1);
      check({tag, "_busy_fall"}, busy, 0);
      check({tag, "_sx"}, sx, esx);
      check({tag, "_sy"}, sy, esy);
      check({tag, "_in_range"}, in_range, ein);
      step();
      check({tag, "_valid_pulse"}, valid, 0);
   endtask

   initial begin
      logic [31:0] esx, esy, ein;
      int n_valid, vat, got_sx, got_sy;
      int vt[$];

      reset_n = 1'b0;
      start   = 1'b0;
      dx      = '0;
      dy      = '0;
      set_q(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_sx", sx, 0);
      check("rst_sy", sy, 0);
      check("rst_in_range", in_range, 0);
      reset_n = 1'b1;
      step();

      set_q(1, 0, 0, 0, 1, 0, 0, 0, 1);
      request(100, 50, "identity");
      set_q(1, 0, 0, 0, 1, 0, 0, 0, 2);
      request(101, 51, "scale");
      set_q(-1, 0, 700, 0, 1, 0, 0, 0, 1);
      request(639, 0, "mirror");
      set_q(1, 0, -200, 0, 1, 0, 0, 0, 1);
      request(100, 50, "negative");
      set_q(1, 0, 600, 0, 1, 0, 0, 0, 1);
      request(100, 50, "overflow");
      set_q(1, 0, 0, 0, 1, 0, 0, 0, 0);
      request(100, 50, "zero_den");
      set_q(1, 0, 0, 0, 1, 0, 0, 0, 1);
      request(639, 479, "corner");

      // Starts arriving mid-request must be dropped.
      set_q(1, 0, 0, 0, 1, 0, 0, 0, 1);
      dx = 10'd100;
      dy = 9'd50;
      start = 1'b1;
      step();
      start = 1'b0;
      n_valid = 0; vat = 0; got_sx = 0; got_sy = 0;
      for (int k = 1; k <= 80; k++) begin
         if (k == 5 || k == 20) begin
            start = 1'b1;
            dx = 10'd200;
            dy = 9'd100;
         end else begin
            start = 1'b0;
         end
         step();
         if (valid) begin
            n_valid++;
            if (n_valid == 1) begin
               vat = k;
               got_sx = int'(sx);
               got_sy = int'(sy);
            end
         end
      end
      start = 1'b0;
      check("ignore_valid_count", n_valid, 1);
      check("ignore_latency", vat, LAT);
      check("ignore_sx", got_sx, 100);
      check("ignore_sy", got_sy, 50);

      // Start held high: a new request every NUM_W+4 cycles.
      model(321, 123, esx, esy, ein);
      dx = 10'd321;
      dy = 9'd123;
      start = 1'b1;
      step();
      for (int k = 1; k <= 3 * (LAT + 1) - 1; k++) begin
         step();
         if (valid) vt.push_back(k);
      end
      start = 1'b0;
      check("b2b_count", vt.size(), 3);
      check("b2b_first", (vt.size() > 0) ? vt[0] : -1, LAT);
      check("b2b_gap1", (vt.size() > 1) ? vt[1] - vt[0] : -1, LAT + 1);
      check("b2b_gap2", (vt.size() > 2) ? vt[2] - vt[1] : -1, LAT + 1);
      check("b2b_sx", sx, esx);
      check("b2b_sy", sy, esy);
      step();
      check("b2b_idle", busy, 0);

      // Asynchronous reset during division.
      set_q(1, 0, 0, 0, 1, 0, 0, 0, 1);
      dx = 10'd77;
      dy = 9'd33;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 15; k++) step();
      check("pre_rst_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_valid", valid, 0);
      check("arst_sx", sx, 0);
      check("arst_sy", sy, 0);
      check("arst_in_range", in_range, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      n_valid = 0;
      for (int k = 1; k <= 50; k++) begin
         step();
         if (valid) n_valid++;
      end
      check("arst_no_valid", n_valid, 0);
      request(77, 33, "after_rst");

      for (int i = 0; i < 24; i++) begin
         if (i % 2 == 0) begin
            set_q(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)) - 2,
                  int'($urandom_range(0, 400)) - 100,
                  int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 400)) - 100,
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 6)) - 1);
         end else begin
            set_q(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                  int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                  int'($urandom));
         end
         request(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), "random");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
